// File: rtl/layer_three.sv
// Binary fully-connected classifier: XNOR-popcount score per digit class, one
// 49-bit filter plane per active cycle, with a running argmax and a sticky done.
module layer_three #(
    parameter int N_IN    = 196,
    parameter int N_CLASS = 10,
    parameter int CHUNK   = 49
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 state,
    input  logic [N_IN-1:0]            features,
    input  logic [N_IN*N_CLASS-1:0]    weights,
    output logic [3:0]                 digit,
    output logic [7:0]                 max_score,
    output logic                       done
);

    localparam logic [2:0] S_LAYER_3 = 3'b100;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } run_state_e;

    run_state_e  fsm_q, fsm_d;
    logic [3:0]  cls_q, cls_d;
    logic [1:0]  chunk_q, chunk_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  best_q, best_d;
    logic [3:0]  digit_q, digit_d;

    logic [7:0]       f_base_s;
    logic [10:0]      w_base_s;
    logic [CHUNK-1:0] feat_s;
    logic [CHUNK-1:0] wgt_s;
    logic [5:0]       part_s;
    logic [7:0]       sum_s;

    function automatic logic [5:0] popcnt49(input logic [CHUNK-1:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

    assign f_base_s = {6'd0, chunk_q} * 8'd49;
    assign w_base_s = {7'd0, cls_q} * 11'd196 + {9'd0, chunk_q} * 11'd49;
    assign feat_s   = features[f_base_s +: CHUNK];
    assign wgt_s    = weights[w_base_s +: CHUNK];
    assign part_s   = popcnt49(~(feat_s ^ wgt_s));
    // Max total is 4*49 = 196, so the 8-bit accumulator never wraps.
    assign sum_s    = acc_q + {2'd0, part_s};

    // Next-state logic: accumulate one plane per active cycle, fold into argmax per class.
    always_comb begin
        fsm_d   = fsm_q;
        cls_d   = cls_q;
        chunk_d = chunk_q;
        acc_d   = acc_q;
        best_d  = best_q;
        digit_d = digit_q;
        case (fsm_q)
            ST_RUN: begin
                if (state == S_LAYER_3) begin
                    if (chunk_q != 2'd3) begin
                        acc_d   = sum_s;
                        chunk_d = chunk_q + 2'd1;
                    end else begin
                        // Strict '>' keeps the lowest class index on ties.
                        if ((cls_q == 4'd0) || (sum_s > best_q)) begin
                            best_d  = sum_s;
                            digit_d = cls_q;
                        end else begin
                            best_d  = best_q;
                            digit_d = digit_q;
                        end
                        acc_d   = 8'd0;
                        chunk_d = 2'd0;
                        if (cls_q == 4'd9) begin
                            fsm_d = ST_DONE;
                        end else begin
                            cls_d = cls_q + 4'd1;
                        end
                    end
                end else begin
                    fsm_d = fsm_q;
                end
            end
            ST_DONE: begin
                fsm_d = ST_DONE;
            end
            default: begin
                fsm_d = ST_RUN;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_RUN;
            cls_q   <= 4'd0;
            chunk_q <= 2'd0;
            acc_q   <= 8'd0;
            best_q  <= 8'd0;
            digit_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            cls_q   <= cls_d;
            chunk_q <= chunk_d;
            acc_q   <= acc_d;
            best_q  <= best_d;
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign max_score = best_q;
    assign done      = (fsm_q == ST_DONE);

endmodule
